// File: rtl/divider_pkg.sv
// Shared types and constants for the restoring divider.
// The state encoding is exported so that checkers can observe the FSM directly.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // All-ones quotient returned for a zero divisor.
    // Users slice the low WIDTH bits of this constant.
    localparam int MAX_WIDTH = 1024;
    localparam logic [MAX_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

    // The counter has to hold the value WIDTH itself, not only WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/divider_subtractor.sv
// Ripple-borrow subtractor built from full_subtractor cells.
// Mirrors the adder structure; Bout is the borrow out of the top bit.
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic Diff,
    output logic Bout
);

    assign Diff = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

module subtractor #(
    parameter int WIDTH = 33
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
);

    logic [WIDTH:0] borrow;

    assign borrow[0] = Bin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_subtractor u_fs (
            .A    (A[i]),
            .B    (B[i]),
            .Bin  (borrow[i]),
            .Diff (Diff[i]),
            .Bout (borrow[i+1])
        );
    end

    assign Bout = borrow[WIDTH];

endmodule

// File: rtl/divider.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock.
// The quotient/remainder working registers double as the result registers.
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic [WIDTH-1:0] QUOTIENT,
    output logic [WIDTH-1:0] REMAINDER,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIV_ZERO,
    output state_t           STATE
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

    // Handshake: START is a request sampled on a rising edge only while
    // BUSY is low (state IDLE or FINISH); BUSY high means the request is
    // dropped. DONE is a one-cycle strobe, and the results stay valid until
    // the next accepted START.

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dsr;
    logic [CW-1:0]    cnt;
    logic             dz;

    logic             accept;
    logic             zero_div;
    logic             iterate;
    logic [WIDTH:0]   sh_rem;
    logic [WIDTH-1:0] sh_quo;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic             unused_trial_msb;

    assign accept   = START && (state != RUN);
    assign zero_div = (DIVISOR == '0);
    assign iterate  = (state == RUN) && (cnt != LAST_CNT);

    assign sh_rem = {rem, quo[WIDTH-1]};
    assign sh_quo = {quo[WIDTH-2:0], 1'b0};

    subtractor #(
        .WIDTH (WIDTH + 1)
    ) u_sub (
        .A    (sh_rem),
        .B    ({1'b0, dsr}),
        .Bin  (1'b0),
        .Diff (trial),
        .Bout (borrow)
    );

    // The remainder stays below the divisor, so a successful trial never sets the MSB.
    assign unused_trial_msb = trial[WIDTH];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = zero_div ? FINISH : RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_CNT) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                if (accept) begin
                    state_next = zero_div ? FINISH : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            quo <= '0;
            rem <= '0;
            dsr <= '0;
            cnt <= '0;
            dz  <= 1'b0;
        end else if (accept) begin
            dsr <= DIVISOR;
            cnt <= '0;
            if (zero_div) begin
                quo <= DIV_ZERO_QUOTIENT[WIDTH-1:0];
                rem <= DIVIDEND;
                dz  <= 1'b1;
            end else begin
                quo <= DIVIDEND;
                rem <= '0;
                dz  <= 1'b0;
            end
        end else if (iterate) begin
            // Restoring step: keep the shifted remainder on borrow, else take the difference.
            rem <= borrow ? sh_rem[WIDTH-1:0] : trial[WIDTH-1:0];
            quo <= {sh_quo[WIDTH-1:1], ~borrow};
            cnt <= cnt + 1'b1;
        end
    end

    assign QUOTIENT  = quo;
    assign REMAINDER = rem;
    assign BUSY      = (state == RUN);
    assign DONE      = (state == FINISH);
    assign DIV_ZERO  = dz;
    assign STATE     = state;

endmodule

// File: tb/tb_divider.sv
// Directed and swept checks of the restoring divider at WIDTH=32.
// Latency is counted in cycles after the START edge (the START edge cycle is 1).
module tb_divider;
    import divider_pkg::*;

    localparam int W = 32;
    localparam logic [W-1:0] ONES = 32'hFFFF_FFFF;

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic [W-1:0] DIVIDEND;
    logic [W-1:0] DIVISOR;
    logic [W-1:0] QUOTIENT;
    logic [W-1:0] REMAINDER;
    logic         BUSY;
    logic         DONE;
    logic         DIV_ZERO;
    state_t       STATE;

    int n_checks = 0;
    int n_pass   = 0;
    bit busy_seen;
    logic [2*W-1:0] exp_q[$];

    divider #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .DIVIDEND  (DIVIDEND),
        .DIVISOR   (DIVISOR),
        .QUOTIENT  (QUOTIENT),
        .REMAINDER (REMAINDER),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .DIV_ZERO  (DIV_ZERO),
        .STATE     (STATE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        START    = 1'b1;
        DIVIDEND = a;
        DIVISOR  = b;
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int cyc);
        cyc       = c0;
        busy_seen = BUSY;
        while (!DONE && cyc < 200) begin
            @(posedge CLK);
            #1;
            cyc++;
            busy_seen |= BUSY;
        end
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r,
                         input logic dz, input int lat);
        int cyc;
        issue(a, b);
        wait_done(1, cyc);
        check({tag, ".latency"}, 64'(cyc), 64'(lat));
        check({tag, ".quotient"}, 64'(QUOTIENT), 64'(q));
        check({tag, ".remainder"}, 64'(REMAINDER), 64'(r));
        check({tag, ".div_zero"}, 64'(DIV_ZERO), 64'(dz));
    endtask

    initial begin
        int cyc;
        bit done_seen;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2*W-1:0] e;

        RST      = 1'b1;
        START    = 1'b0;
        DIVIDEND = '0;
        DIVISOR  = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        check("rst.quotient", 64'(QUOTIENT), 64'd0);
        check("rst.remainder", 64'(REMAINDER), 64'd0);
        check("rst.busy", 64'(BUSY), 64'd0);
        check("rst.done", 64'(DONE), 64'd0);
        check("rst.div_zero", 64'(DIV_ZERO), 64'd0);
        check("rst.state", 64'(STATE), 64'(IDLE));

        do_op("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
        @(posedge CLK);
        #1;
        check("pulse.done", 64'(DONE), 64'd0);
        check("pulse.state", 64'(STATE), 64'(IDLE));
        check("hold.quotient", 64'(QUOTIENT), 64'd14);
        check("hold.remainder", 64'(REMAINDER), 64'd2);

        do_op("max/1", ONES, 32'd1, ONES, 32'd0, 1'b0, 34);
        do_op("5/10", 32'd5, 32'd10, 32'd0, 32'd5, 1'b0, 34);
        do_op("1234/0", 32'd1234, 32'd0, ONES, 32'd1234, 1'b1, 1);
        check("1234/0.busy_seen", 64'(busy_seen), 64'd0);
        do_op("0/5", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 34);
        check("0/5.div_zero_cleared", 64'(DIV_ZERO), 64'd0);
        do_op("max/max", ONES, ONES, 32'd1, 32'd0, 1'b0, 34);
        do_op("8000_0000/3", 32'h8000_0000, 32'd3, 32'd715827882, 32'd2, 1'b0, 34);

        // START during RUN must be ignored.
        issue(32'd100, 32'd7);
        repeat (9) begin
            @(posedge CLK);
            #1;
        end
        check("ign.busy", 64'(BUSY), 64'd1);
        START    = 1'b1;
        DIVIDEND = 32'd9;
        DIVISOR  = 32'd3;
        @(posedge CLK);
        #1;
        START = 1'b0;
        wait_done(11, cyc);
        check("ign.latency", 64'(cyc), 64'd34);
        check("ign.quotient", 64'(QUOTIENT), 64'd14);
        check("ign.remainder", 64'(REMAINDER), 64'd2);
        // Back-to-back: START in the DONE cycle is accepted.
        do_op("b2b.9/3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);

        // Reset in the middle of an operation.
        issue(32'd1000, 32'd10);
        repeat (14) begin
            @(posedge CLK);
            #1;
        end
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("abort.quotient", 64'(QUOTIENT), 64'd0);
        check("abort.remainder", 64'(REMAINDER), 64'd0);
        check("abort.busy", 64'(BUSY), 64'd0);
        check("abort.state", 64'(STATE), 64'(IDLE));
        done_seen = 1'b0;
        repeat (40) begin
            done_seen |= DONE;
            @(posedge CLK);
            #1;
        end
        check("abort.no_done", 64'(done_seen), 64'd0);
        do_op("1000/10", 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 34);

        for (int i = 0; i < 1000; i++) begin
            case (i % 8)
                0: begin a = '0; b = $urandom; end
                1: begin a = ONES; b = $urandom; end
                2: begin a = $urandom; b = '0; end
                3: begin a = $urandom; b = ONES; end
                4: begin a = $urandom; b = 32'($urandom_range(1, 15)); end
                5: begin a = 32'($urandom_range(0, 1000)); b = $urandom; end
                default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
            endcase
            if (b == '0) begin
                exp_q.push_back({ONES, a});
            end else begin
                exp_q.push_back({a / b, a % b});
            end
            e = exp_q.pop_front();
            do_op($sformatf("sweep%0d", i), a, b, e[2*W-1:W], e[W-1:0],
                  (b == '0), (b == '0) ? 1 : 34);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
